sram_axi_arbiter: RTL and testbench



---
 rtl/sram_axi_arbiter.sv | 107 ++++++++++
 tb/tb_sram_axi_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: round-robin, whole-transaction arbiter sharing one SRAM AXI-lite slave between IFU and LSU
module sram_axi_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_arvalid,
  input  logic [AW-1:0] ifu_araddr,
  output logic          ifu_arready,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  output logic [1:0]    ifu_rresp,
  input  logic          ifu_rready,
  input  logic          lsu_arvalid,
  input  logic [AW-1:0] lsu_araddr,
  output logic          lsu_arready,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic [1:0]    lsu_rresp,
  input  logic          lsu_rready,
  input  logic          lsu_awvalid,
  input  logic [AW-1:0] lsu_awaddr,
  output logic          lsu_awready,
  input  logic          lsu_wvalid,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [SW-1:0] lsu_wstrb,
  output logic          lsu_wready,
  output logic          lsu_bvalid,
  output logic [1:0]    lsu_bresp,
  input  logic          lsu_bready,
  output logic          sram_arvalid,
  output logic [AW-1:0] sram_araddr,
  input  logic          sram_arready,
  input  logic          sram_rvalid,
  input  logic [DW-1:0] sram_rdata,
  input  logic [1:0]    sram_rresp,
  output logic          sram_rready,
  output logic          sram_awvalid,
  output logic [AW-1:0] sram_awaddr,
  input  logic          sram_awready,
  output logic          sram_wvalid,
  output logic [DW-1:0] sram_wdata,
  output logic [SW-1:0] sram_wstrb,
  input  logic          sram_wready,
  input  logic          sram_bvalid,
  input  logic [1:0]    sram_bresp,
  output logic          sram_bready
);
  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;
  state_t state, state_nx;
  logic last_grant;
  logic req_ifu, req_lsu, ifu_g, lr_g, lw_g;
  assign req_ifu = ifu_arvalid;
  assign req_lsu = lsu_arvalid | lsu_awvalid | lsu_wvalid;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_ifu && (!req_lsu || last_grant))
          state_nx = IFU_RD;
        else if (req_lsu)
          state_nx = lsu_arvalid ? LSU_RD : LSU_WR;
      end
      IFU_RD: state_nx = (sram_rvalid && ifu_rready) ? IDLE : IFU_RD;
      LSU_RD: state_nx = (sram_rvalid && lsu_rready) ? IDLE : LSU_RD;
      LSU_WR: state_nx = (sram_bvalid && lsu_bready) ? IDLE : LSU_WR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE)
        last_grant <= (state_nx != IFU_RD);
    end
  end
  assign ifu_g = (state == IFU_RD);
  assign lr_g  = (state == LSU_RD);
  assign lw_g  = (state == LSU_WR);
  // Read channels muxed by grant; every path is gated so idle/ungranted sides read as zero
  assign sram_arvalid = (ifu_g & ifu_arvalid) | (lr_g & lsu_arvalid);
  assign sram_araddr  = ifu_g ? ifu_araddr : lr_g ? lsu_araddr : '0;
  assign sram_rready  = (ifu_g & ifu_rready) | (lr_g & lsu_rready);
  assign ifu_arready  = ifu_g & sram_arready;
  assign ifu_rvalid   = ifu_g & sram_rvalid;
  assign ifu_rdata    = ifu_g ? sram_rdata : '0;
  assign ifu_rresp    = ifu_g ? sram_rresp : '0;
  assign lsu_arready  = lr_g & sram_arready;
  assign lsu_rvalid   = lr_g & sram_rvalid;
  assign lsu_rdata    = lr_g ? sram_rdata : '0;
  assign lsu_rresp    = lr_g ? sram_rresp : '0;
  assign sram_awvalid = lw_g & lsu_awvalid;
  assign sram_awaddr  = lw_g ? lsu_awaddr : '0;
  assign sram_wvalid  = lw_g & lsu_wvalid;
  assign sram_wdata   = lw_g ? lsu_wdata : '0;
  assign sram_wstrb   = lw_g ? lsu_wstrb : '0;
  assign sram_bready  = lw_g & lsu_bready;
  assign lsu_awready  = lw_g & sram_awready;
  assign lsu_wready   = lw_g & sram_wready;
  assign lsu_bvalid   = lw_g & sram_bvalid;
  assign lsu_bresp    = lw_g ? sram_bresp : '0;
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter: directed scenario tests for sram_axi_arbiter with hand-computed expectations
module tb_sram_axi_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ifu_arvalid = 0, ifu_rready = 0, ifu_arready, ifu_rvalid;
  logic [31:0] ifu_araddr = 0, ifu_rdata;
  logic [1:0] ifu_rresp;
  logic lsu_arvalid = 0, lsu_rready = 0, lsu_arready, lsu_rvalid;
  logic [31:0] lsu_araddr = 0, lsu_rdata;
  logic [1:0] lsu_rresp;
  logic lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0, lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] lsu_awaddr = 0, lsu_wdata = 0;
  logic [7:0] lsu_wstrb = 0;
  logic [1:0] lsu_bresp;
  logic sram_arvalid, sram_rready, sram_awvalid, sram_wvalid, sram_bready;
  logic [31:0] sram_araddr, sram_awaddr, sram_wdata;
  logic [7:0] sram_wstrb;
  logic sram_arready = 0, sram_rvalid = 0, sram_awready = 0, sram_wready = 0, sram_bvalid = 0;
  logic [31:0] sram_rdata = 0;
  logic [1:0] sram_rresp = 0, sram_bresp = 0;
  logic [185:0] all_out;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  sram_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .sram_arvalid(sram_arvalid), .sram_araddr(sram_araddr), .sram_arready(sram_arready),
    .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rready(sram_rready),
    .sram_awvalid(sram_awvalid), .sram_awaddr(sram_awaddr), .sram_awready(sram_awready),
    .sram_wvalid(sram_wvalid), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_wready(sram_wready),
    .sram_bvalid(sram_bvalid), .sram_bresp(sram_bresp), .sram_bready(sram_bready)
  );
  assign all_out = {ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid, lsu_rdata,
                    lsu_rresp, lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp, sram_arvalid, sram_araddr,
                    sram_rready, sram_awvalid, sram_awaddr, sram_wvalid, sram_wdata, sram_wstrb, sram_bready};
  task cyc;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    ifu_arvalid = 1; ifu_rready = 1; lsu_awvalid = 1; lsu_wvalid = 1; lsu_bready = 1;
    sram_arready = 1; sram_rvalid = 1; sram_bvalid = 1; sram_awready = 1; sram_wready = 1;
    #2;
    total++; if (all_out !== '0) $display("FAIL reset_async: got %h want 0", all_out); else passed++;
    cyc;
    total++; if (all_out !== '0) $display("FAIL reset_held: got %h want 0", all_out); else passed++;
    ifu_arvalid = 0; ifu_rready = 0; lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 0;
    sram_arready = 0; sram_rvalid = 0; sram_bvalid = 0; sram_awready = 0; sram_wready = 0;
    rst = 1;
    cyc;
  endtask
  task test_ifu_read;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_rready = 1; sram_arready = 1;
    #2;
    total++; if (sram_arvalid !== 1'b0) $display("FAIL ifu_arb_cycle: got %b want 0", sram_arvalid); else passed++;
    cyc; #2;
    total++; if ({sram_arvalid, ifu_arready, sram_araddr} !== {2'b11, 32'h8000_0000})
      $display("FAIL ifu_ar_fwd: got %b%b %h want 11 80000000", sram_arvalid, ifu_arready, sram_araddr); else passed++;
    total++; if ({lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid} !== 5'b0)
      $display("FAIL ifu_lsu_quiet: got %b want 0", {lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}); else passed++;
    cyc; ifu_arvalid = 0; sram_arready = 0;
    cyc;
    cyc; sram_rvalid = 1; sram_rdata = 32'h0000_0413; #2;
    total++; if ({ifu_rvalid, sram_rready, ifu_rdata} !== {2'b11, 32'h0000_0413})
      $display("FAIL ifu_r_fwd: got %b%b %h want 11 00000413", ifu_rvalid, sram_rready, ifu_rdata); else passed++;
    cyc; sram_rvalid = 0; #2;
    total++; if (sram_rready !== 1'b0) $display("FAIL ifu_back_idle: got %b want 0", sram_rready); else passed++;
    ifu_rready = 0;
  endtask
  task test_lsu_store;
    lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 8'h0F; lsu_bready = 1;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0004; ifu_rready = 1; sram_arready = 1;
    #2;
    total++; if (sram_wvalid !== 1'b0) $display("FAIL st_arb_cycle: got %b want 0", sram_wvalid); else passed++;
    cyc; #2;
    total++; if ({sram_wvalid, sram_wdata, sram_wstrb, sram_awvalid} !== {1'b1, 32'hDEAD_BEEF, 8'h0F, 1'b0})
      $display("FAIL st_w_fwd: got %b %h %h %b want 1 deadbeef 0f 0", sram_wvalid, sram_wdata, sram_wstrb, sram_awvalid); else passed++;
    total++; if ({ifu_arready, sram_arvalid} !== 2'b00)
      $display("FAIL st_ifu_blocked: got %b want 00", {ifu_arready, sram_arvalid}); else passed++;
    cyc;
    cyc; lsu_awvalid = 1; lsu_awaddr = 32'h8000_1000; sram_awready = 1; sram_wready = 1; #2;
    total++; if ({sram_awvalid, sram_awaddr, lsu_awready, lsu_wready} !== {1'b1, 32'h8000_1000, 2'b11})
      $display("FAIL st_aw_fwd: got %b %h %b%b want 1 80001000 11", sram_awvalid, sram_awaddr, lsu_awready, lsu_wready); else passed++;
    cyc; lsu_awvalid = 0; lsu_wvalid = 0; sram_awready = 0; sram_wready = 0; sram_bvalid = 1; sram_bresp = 2'b00; #2;
    total++; if ({lsu_bvalid, sram_bready, ifu_arready} !== 3'b110)
      $display("FAIL st_b_fwd: got %b want 110", {lsu_bvalid, sram_bready, ifu_arready}); else passed++;
    cyc; sram_bvalid = 0; lsu_bready = 0; #2;
    total++; if (sram_arvalid !== 1'b0) $display("FAIL st_idle_gap: got %b want 0", sram_arvalid); else passed++;
    cyc; #2;
    total++; if ({sram_arvalid, sram_araddr} !== {1'b1, 32'h8000_0004})
      $display("FAIL st_ifu_pending: got %b %h want 1 80000004", sram_arvalid, sram_araddr); else passed++;
    cyc; ifu_arvalid = 0; sram_arready = 0; sram_rvalid = 1; sram_rdata = 32'h00A0_0093; #2;
    total++; if (ifu_rdata !== 32'h00A0_0093) $display("FAIL st_ifu_rdata: got %h want 00a00093", ifu_rdata); else passed++;
    cyc; sram_rvalid = 0; ifu_rready = 0;
  endtask
  task test_alternation;
    logic g;
    rst = 0; cyc; rst = 1;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_00A0; lsu_arvalid = 1; lsu_araddr = 32'h8000_20B0;
    ifu_rready = 1; lsu_rready = 1; sram_arready = 1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0);
      #2;
      total++; if (sram_arvalid !== 1'b0) $display("FAIL alt%0d_idle: got %b want 0", k, sram_arvalid); else passed++;
      cyc; #2;
      total++; if ({ifu_arready, lsu_arready, sram_araddr} !== {g, !g, g ? 32'h8000_00A0 : 32'h8000_20B0})
        $display("FAIL alt%0d_grant: got %b%b %h want %b%b", k, ifu_arready, lsu_arready, sram_araddr, g, !g); else passed++;
      cyc;
      if (g) ifu_arvalid = 0; else lsu_arvalid = 0;
      sram_rvalid = 1; sram_rdata = 32'h100 + k; #2;
      total++; if ({ifu_rvalid, lsu_rvalid, (g ? ifu_rdata : lsu_rdata)} !== {g, !g, 32'h100 + k})
        $display("FAIL alt%0d_rdata: got %b%b %h %h want %b%b %h", k, ifu_rvalid, lsu_rvalid, ifu_rdata, lsu_rdata, g, !g, 32'h100 + k); else passed++;
      cyc; sram_rvalid = 0;
      if (g) ifu_arvalid = 1; else lsu_arvalid = 1;
    end
    ifu_arvalid = 0; lsu_arvalid = 0; ifu_rready = 0; lsu_rready = 0; sram_arready = 0;
    cyc;
  endtask
  task test_rd_before_wr;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_2000; lsu_awvalid = 1; lsu_awaddr = 32'h8000_2004;
    lsu_wvalid = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 8'hFF; lsu_rready = 1; lsu_bready = 1; sram_arready = 1;
    cyc; #2;
    total++; if ({sram_arvalid, sram_araddr, sram_awvalid, sram_wvalid} !== {1'b1, 32'h8000_2000, 2'b00})
      $display("FAIL rw_read_first: got %b %h %b%b want 1 80002000 00", sram_arvalid, sram_araddr, sram_awvalid, sram_wvalid); else passed++;
    cyc; lsu_arvalid = 0; sram_arready = 0; sram_rvalid = 1; sram_rdata = 32'h1234_5678; sram_rresp = 2'b01; #2;
    total++; if ({lsu_rvalid, lsu_rdata, lsu_rresp} !== {1'b1, 32'h1234_5678, 2'b01})
      $display("FAIL rw_rdata: got %b %h %b want 1 12345678 01", lsu_rvalid, lsu_rdata, lsu_rresp); else passed++;
    cyc; sram_rvalid = 0; sram_rresp = 0; #2;
    total++; if (sram_awvalid !== 1'b0) $display("FAIL rw_idle_gap: got %b want 0", sram_awvalid); else passed++;
    cyc; sram_awready = 1; sram_wready = 1; #2;
    total++; if ({sram_awvalid, sram_awaddr, sram_wvalid, sram_wdata, sram_wstrb} !== {1'b1, 32'h8000_2004, 1'b1, 32'hCAFE_F00D, 8'hFF})
      $display("FAIL rw_write: got %b %h %b %h %h want 1 80002004 1 cafef00d ff", sram_awvalid, sram_awaddr, sram_wvalid, sram_wdata, sram_wstrb); else passed++;
    cyc; lsu_awvalid = 0; lsu_wvalid = 0; sram_awready = 0; sram_wready = 0; sram_bvalid = 1; sram_bresp = 2'b10; #2;
    total++; if ({lsu_bvalid, lsu_bresp} !== 3'b110) $display("FAIL rw_bresp: got %b%b want 110", lsu_bvalid, lsu_bresp); else passed++;
    cyc; sram_bvalid = 0; sram_bresp = 0; lsu_rready = 0; lsu_bready = 0;
  endtask
  task test_spurious_b;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0010; ifu_rready = 1; sram_arready = 1;
    cyc;
    cyc; ifu_arvalid = 0; sram_arready = 0; sram_bvalid = 1; lsu_bready = 1; #2;
    total++; if ({lsu_bvalid, sram_bready} !== 2'b00) $display("FAIL spur_b_blocked: got %b want 00", {lsu_bvalid, sram_bready}); else passed++;
    cyc; sram_bvalid = 0; sram_rvalid = 1; sram_rdata = 32'h0000_0073; #2;
    total++; if ({sram_rready, ifu_rvalid, ifu_rdata} !== {2'b11, 32'h0000_0073})
      $display("FAIL spur_state_kept: got %b%b %h want 11 00000073", sram_rready, ifu_rvalid, ifu_rdata); else passed++;
    cyc; sram_rvalid = 0; lsu_bready = 0; #2;
    total++; if (sram_rready !== 1'b0) $display("FAIL spur_idle: got %b want 0", sram_rready); else passed++;
    ifu_rready = 0;
  endtask
  task test_reset_mid;
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_3000; lsu_wvalid = 1; lsu_wdata = 32'h1111_2222; lsu_wstrb = 8'h0F; lsu_bready = 1;
    cyc; #2;
    total++; if ({sram_awvalid, sram_awaddr} !== {1'b1, 32'h8000_3000})
      $display("FAIL rmid_granted: got %b %h want 1 80003000", sram_awvalid, sram_awaddr); else passed++;
    rst = 0; #1;
    total++; if (all_out !== '0) $display("FAIL rmid_drop: got %h want 0", all_out); else passed++;
    cyc; rst = 1; #2;
    total++; if (all_out !== '0) $display("FAIL rmid_idle: got %h want 0", all_out); else passed++;
    cyc; sram_awready = 1; sram_wready = 1; #2;
    total++; if ({sram_awvalid, sram_wvalid, sram_wdata, lsu_awready} !== {2'b11, 32'h1111_2222, 1'b1})
      $display("FAIL rmid_regrant: got %b%b %h %b want 11 11112222 1", sram_awvalid, sram_wvalid, sram_wdata, lsu_awready); else passed++;
    cyc; lsu_awvalid = 0; lsu_wvalid = 0; sram_awready = 0; sram_wready = 0; sram_bvalid = 1; #2;
    total++; if (lsu_bvalid !== 1'b1) $display("FAIL rmid_b: got %b want 1", lsu_bvalid); else passed++;
    cyc; sram_bvalid = 0; lsu_bready = 0;
  endtask
  initial begin
    test_reset;
    test_ifu_read;
    test_lsu_store;
    test_alternation;
    test_rd_before_wr;
    test_spurious_b;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
